// File: rtl/countdown_ncycle.sv
// countdown_ncycle: loadable down-counter with one-cycle done pulse on expiry.
// Define COUNTDOWN_AUTORELOAD_EN to reload the start value on expiry instead of stopping.
`default_nettype none

module countdown_ncycle #(
  parameter int NBIT = 5
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            enable,
  input  logic            load,
  input  logic [NBIT-1:0] loadvalue,
  output logic [NBIT-1:0] counterout,
  output logic            busy,
  output logic            done
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam logic [NBIT-1:0] ONE = {{(NBIT-1){1'b0}}, 1'b1};

  state_t          state, state_nxt;
  logic [NBIT-1:0] count_nxt;
  logic            busy_nxt;
  logic            done_nxt;

`ifdef COUNTDOWN_AUTORELOAD_EN
  // Start value is only needed to restart the run on expiry.
  logic [NBIT-1:0] reload, reload_nxt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      reload <= '0;
    end else begin
      reload <= reload_nxt;
    end
  end
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      counterout <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      state      <= state_nxt;
      counterout <= count_nxt;
      busy       <= busy_nxt;
      done       <= done_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    count_nxt  = counterout;
    busy_nxt   = busy;
    done_nxt   = 1'b0;
`ifdef COUNTDOWN_AUTORELOAD_EN
    reload_nxt = reload;
`endif

    if (load) begin
      count_nxt = loadvalue;
`ifdef COUNTDOWN_AUTORELOAD_EN
      reload_nxt = loadvalue;
`endif
      if (loadvalue != '0) begin
        state_nxt = RUN;
        busy_nxt  = 1'b1;
      end else begin
        // A zero-length run expires immediately.
        state_nxt = IDLE;
        busy_nxt  = 1'b0;
        done_nxt  = 1'b1;
      end
    end else if (state == RUN && enable) begin
      if (counterout > ONE) begin
        count_nxt = counterout - ONE;
      end else begin
        done_nxt = 1'b1;
`ifdef COUNTDOWN_AUTORELOAD_EN
        count_nxt = reload;
`else
        count_nxt = '0;
        state_nxt = IDLE;
        busy_nxt  = 1'b0;
`endif
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_countdown_ncycle.sv
// tb_countdown_ncycle: directed self-checking bench for countdown_ncycle (both builds).
`default_nettype none

module tb_countdown_ncycle;

  localparam int NBIT = 5;
`ifdef COUNTDOWN_AUTORELOAD_EN
  localparam bit AR = 1'b1;
`else
  localparam bit AR = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            reset;
  logic            enable;
  logic            load;
  logic [NBIT-1:0] loadvalue;
  logic [NBIT-1:0] counterout;
  logic            busy;
  logic            done;

  int errors = 0;
  int checks = 0;

  countdown_ncycle #(.NBIT(NBIT)) dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .load       (load),
    .loadvalue  (loadvalue),
    .counterout (counterout),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic expect3(input string tag, input int c, input int b, input int d);
    check({tag, ".count"}, int'(counterout), c);
    check({tag, ".busy"},  int'(busy), b);
    check({tag, ".done"},  int'(done), d);
  endtask

  // Advance one rising edge, then settle so outputs are sampled away from the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic stop_with_zero_load(input string tag);
    load = 1'b1; loadvalue = '0;
    tick();
    expect3({tag, ".zload"}, 0, 0, 1);
    load = 1'b0;
    tick();
    expect3({tag, ".after"}, 0, 0, 0);
  endtask

  initial begin
    reset = 1'b0; enable = 1'b0; load = 1'b0; loadvalue = '0;

    // Reset and idle behaviour
    repeat (3) tick();
    expect3("reset", 0, 0, 0);
    reset = 1'b1; enable = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      expect3("idle_en", 0, 0, 0);
    end

    // Load 5, count down with enable held high
    load = 1'b1; loadvalue = 5'd5;
    tick();
    expect3("n5.load", 5, 1, 0);
    load = 1'b0;
    for (int j = 1; j < 5; j++) begin
      tick();
      expect3("n5.run", 5 - j, 1, 0);
    end
    tick();
    expect3("n5.term", AR ? 5 : 0, AR ? 1 : 0, 1);
    tick();
    expect3("n5.post", AR ? 4 : 0, AR ? 1 : 0, 0);
    stop_with_zero_load("n5");

    // Load 4 with enable alternating: each count held two cycles
    load = 1'b1; loadvalue = 5'd4;
    tick();
    expect3("tog.load", 4, 1, 0);
    load = 1'b0;
    for (int i = 1; i < 8; i++) begin
      enable = (i % 2 == 0);
      tick();
      expect3("tog.run", 4 - i / 2, 1, 0);
    end
    enable = 1'b1;
    tick();
    expect3("tog.term", AR ? 4 : 0, AR ? 1 : 0, 1);
    stop_with_zero_load("tog");

    // Reload mid-run: 6 -> three decrements -> load 2
    load = 1'b1; loadvalue = 5'd6;
    tick();
    load = 1'b0;
    repeat (3) tick();
    expect3("rel.mid", 3, 1, 0);
    load = 1'b1; loadvalue = 5'd2;
    tick();
    expect3("rel.load", 2, 1, 0);
    load = 1'b0;
    tick();
    expect3("rel.run", 1, 1, 0);
    tick();
    expect3("rel.term", AR ? 2 : 0, AR ? 1 : 0, 1);
    stop_with_zero_load("rel");

    // Load on the terminal edge aborts the run without done
    load = 1'b1; loadvalue = 5'd1;
    tick();
    expect3("tload.load1", 1, 1, 0);
    loadvalue = 5'd3;
    tick();
    expect3("tload.load3", 3, 1, 0);
    load = 1'b0;
    tick();
    expect3("tload.r2", 2, 1, 0);
    tick();
    expect3("tload.r1", 1, 1, 0);
    tick();
    expect3("tload.term", AR ? 3 : 0, AR ? 1 : 0, 1);
    stop_with_zero_load("tload");

    // Asynchronous reset mid-run
    load = 1'b1; loadvalue = 5'd5;
    tick();
    load = 1'b0;
    tick(); tick();
    expect3("arst.pre", 3, 1, 0);
    reset = 1'b0;
    #1;
    expect3("arst.async", 0, 0, 0);
    tick();
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      expect3("arst.idle", 0, 0, 0);
    end

    // Full-scale load value
    load = 1'b1; loadvalue = 5'd31;
    tick();
    expect3("max.load", 31, 1, 0);
    load = 1'b0;
    tick();
    expect3("max.run", 30, 1, 0);
    stop_with_zero_load("max");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
